// File: rtl/display_scan_ctrl.sv
// Binary-to-BCD conversion (shift-and-add-3) feeding a three-digit multiplexed
// seven-segment scanner with optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] numero,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_shift;
  logic [11:0]     r_shadow;
  logic [2:0]      r_step;
  logic [3:0]      r_hund;
  logic [3:0]      r_tens;
  logic [3:0]      r_unit;
  logic            r_done;
  logic [PW-1:0]   r_pre;
  logic [1:0]      r_idx;
  logic [2:0]      r_an;
  logic [6:0]      r_seg;
  logic [11:0]     w_adj;
  logic            w_unused_msb;
  logic            w_tc;
  logic [3:0]      w_digit;
  logic            w_blank;
  logic [2:0]      w_an;
  logic [6:0]      w_seg;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_next = S_CONV;
      S_CONV:   if (r_step == 3'd7) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = r_done;
  end

  // The top nibble's MSB is shifted out; for 8-bit input it is always zero.
  assign w_adj        = add3(r_shadow);
  assign w_unused_msb = w_adj[11];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_shadow <= '0;
      r_step   <= '0;
      r_hund   <= '0;
      r_tens   <= '0;
      r_unit   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_COMMIT);
      case (r_state)
        S_IDLE: if (load) begin
          r_shift  <= numero;
          r_shadow <= '0;
          r_step   <= '0;
        end
        S_CONV: begin
          r_shadow <= {w_adj[10:0], r_shift[7]};
          r_shift  <= {r_shift[6:0], 1'b0};
          r_step   <= r_step + 3'd1;
        end
        S_COMMIT: begin
          r_hund <= r_shadow[11:8];
          r_tens <= r_shadow[7:4];
          r_unit <= r_shadow[3:0];
        end
        default: ;
      endcase
    end
  end

  assign w_tc = (r_pre == PW'(REFRESH_DIV - 1));

  always_comb begin
    w_digit = r_unit;
    w_blank = 1'b0;
    w_an    = 3'b110;
    case (r_idx)
      2'd1: begin
        w_digit = r_tens;
        w_blank = BLANK_LZ && (r_hund == 4'd0) && (r_tens == 4'd0);
        w_an    = 3'b101;
      end
      2'd2: begin
        w_digit = r_hund;
        w_blank = BLANK_LZ && (r_hund == 4'd0);
        w_an    = 3'b011;
      end
      default: ;
    endcase
    w_seg = decode(w_digit);
    if (w_blank) begin
      w_an  = 3'b111;
      w_seg = 7'b1111111;
    end
  end

  // Scanner is free-running; the slot shown is the index before it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= 3'b111;
      r_seg <= 7'b1111111;
    end else if (w_tc) begin
      r_pre <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      r_an  <= w_an;
      r_seg <= w_seg;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed + randomized bench for display_scan_ctrl; two instances differ only
// in leading-zero blanking and share all inputs.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] numero;
  logic       load;
  logic       busy1, done1, busy0, done0;
  logic [2:0] an1, an0;
  logic [6:0] seg1, seg0;
  int         cyc;
  int         n_cmp = 0;
  int         n_bad = 0;

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .numero(numero), .load(load),
    .busy(busy1), .done(done1), .an(an1), .seg(seg1)
  );

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .numero(numero), .load(load),
    .busy(busy0), .done(done0), .an(an0), .seg(seg0)
  );

  always #5 clk = ~clk;

  // Edges since reset release: the scan slot follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  // Expected {an, seg} after c edges since reset, with value v committed.
  function automatic logic [9:0] exp_scan(input int v, input int c, input bit blz);
    int  s, d;
    bit  blank;
    if (c < DIV) return {3'b111, 7'b1111111};
    s = (c / DIV - 1) % 3;
    d = (s == 0) ? v % 10 : (s == 1) ? (v / 10) % 10 : v / 100;
    blank = blz && ((s == 2 && v < 100) || (s == 1 && v < 10));
    if (blank) return {3'b111, 7'b1111111};
    return {~(3'b001 << s), seg_of(d)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {busy1, busy0}, 2'b00);
    chk({tag, "_done"}, {done1, done0}, 2'b00);
    chk({tag, "_an"},   {an1, an0},     6'b111111);
    chk({tag, "_seg"},  {seg1, seg0},   14'h3FFF);
  endtask

  // Observe three full scan slots against the model; v must be stable.
  task automatic check_scan(input int v, input string tag);
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      chk({tag, "_blz1"}, {an1, seg1}, exp_scan(v, cyc, 1'b1));
      chk({tag, "_blz0"}, {an0, seg0}, exp_scan(v, cyc, 1'b0));
      chk({tag, "_onelow"}, ($countones(~an1) <= 1) && ($countones(~an0) <= 1), 1);
    end
  endtask

  // Issue one conversion; with glitch set, hold load high with value gv while busy.
  task automatic conv(input int v, input bit glitch, input int gv, input string tag);
    int dones;
    dones = 0;
    @(negedge clk);
    numero = 8'(v);
    load   = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      load   = glitch && (i < 9);
      numero = glitch ? 8'(gv) : 8'($urandom);
      if (done1) dones++;
      if (i <= 9) begin
        chk({tag, "_busy"}, {busy1, busy0}, 2'b11);
        chk({tag, "_done_early"}, {done1, done0}, 2'b00);
      end else if (i == 10) begin
        chk({tag, "_busy_end"}, {busy1, busy0}, 2'b00);
        chk({tag, "_done"}, {done1, done0}, 2'b11);
      end else begin
        chk({tag, "_done_1cyc"}, {done1, done0}, 2'b00);
      end
    end
    load = 1'b0;
    chk({tag, "_ndone"}, dones, 1);
    repeat (DIV) @(negedge clk);
    check_scan(v, tag);
  endtask

  initial begin
    int v;
    rst_n  = 1'b0;
    load   = 1'b0;
    numero = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check_scan(0, "post_reset");

    conv(255, 1'b0, 0, "v255");
    conv(7,   1'b0, 0, "v7");
    conv(100, 1'b0, 0, "v100");
    conv(42,  1'b1, 99, "v42_ignore99");

    // Reset during a conversion of 200.
    @(negedge clk);
    numero = 8'd200;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done1, done0, busy1}, 3'b000);
    end
    conv(13, 1'b0, 0, "v13");

    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 255));
      conv(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), "rand");
    end

    for (int i = 0; i < 256; i++) conv(i, 1'b0, 0, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 blanks leading zeros, 0 shows all three digits.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port numero, input, 8: unsigned binary value to convert; sampled only when a load is accepted.
REQ-006 Port load, input, 1: conversion request, level-sampled each edge.
REQ-007 Port busy, output, 1: high while a conversion is in progress.
REQ-008 Port done, output, 1: one-cycle pulse when new digits are committed to the display.
REQ-009 Port an, output, 3: active-low digit enables; bit0 units, bit1 tens, bit2 hundreds.
REQ-010 Port seg, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.

Function
REQ-011 Conversion FSM states: IDLE, CONV, COMMIT; no other states are reachable.
REQ-012 IDLE: load=1 at edge N captures numero into an 8-bit shift register, clears the 12-bit shadow BCD to 0, zeroes a 3-bit step counter and enters CONV.
REQ-013 load=1 while in CONV or COMMIT is ignored; there is no queueing, and numero changes have no effect.
REQ-014 CONV: each of edges N+1..N+8 adds 3 to every shadow nibble that is >=5, then shifts {shadow, shift register} left by one bit (shift-register MSB enters units LSB).
REQ-015 On edge N+8 the step counter reads 7 and the FSM enters COMMIT.
REQ-016 COMMIT, edge N+9: display registers (hund, tens, unit) are loaded from the shadow, done=1 for exactly one cycle, and the FSM returns to IDLE.
REQ-017 busy=1 from after edge N until edge N+9 (9 cycles); a new load is accepted no earlier than edge N+10.
REQ-018 Display registers change only in COMMIT; the scan always shows the last committed value and never a partial one.
REQ-019 Scan prescaler counts 0..REFRESH_DIV-1 and wraps; at the terminal count, the digit index advances 0->1->2->0.
REQ-020 Scan runs continuously from reset, independent of the FSM; a COMMIT does not reset the prescaler or the index.
REQ-021 an and seg are registered and update on the same edge as the index; the index selects digit 0 -> an=3'b110, 1 -> 3'b101, 2 -> 3'b011.
REQ-022 seg decode for the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10..15=1111111.
REQ-023 With BLANK_LZ=1: hundreds is blanked when hund=0; tens is blanked when hund=0 and tens=0; units is never blanked.
REQ-024 A blanked digit drives an=3'b111 and seg=1111111 for its whole slot; the slot timing is unchanged.
REQ-025 With BLANK_LZ=0, no digit is ever blanked.
REQ-026 At most one an bit is low in any cycle.

Reset
REQ-027 rst_n=0 immediately forces: FSM=IDLE; busy=0; done=0; an=3'b111; seg=1111111; prescaler, index, step counter, shift register, shadow and display registers all 0.
REQ-028 A reset during CONV or COMMIT aborts the conversion: no done pulse, and the display returns to showing 0.
REQ-029 After rst_n rises, the first scan update occurs at prescaler terminal count; the units digit then shows 0 (seg=1000000, an=3'b110).

Verification
REQ-030 REFRESH_DIV=4, numero=255, load pulsed in IDLE -> busy high 9 cycles, done pulse 9 cycles after acceptance, scan shows units 5, tens 5, hundreds 2.
REQ-031 numero=7, BLANK_LZ=1 -> units seg=1111000; tens and hundreds slots show an=111, seg=1111111; with BLANK_LZ=0, tens and hundreds both show 1000000.
REQ-032 numero=100 -> hundreds 1, tens 0 shown (not blanked), units 0.
REQ-033 Load 42, then load=1 with numero=99 during busy -> 99 ignored, display shows 42, exactly one done pulse.
REQ-034 rst_n low at cycle 4 of a conversion of 200 -> no done pulse, all outputs at reset values, later load of 13 converts correctly.
REQ-035 Sweep numero 0..255 against a reference model -> committed digits match value/100, (value/10)%10 and value%10 in every case.
